// File: rtl/nios2_cpu_div_cell.sv
// nios2_cpu_div_cell: iterative radix-2 non-restoring 32-bit divider for the M stage.
// Serves div, divu and the remainder path. Stalls the pipeline through M_div_busy.
// Optional build macro: NIOS2_DIV_FAST_ZERO_EN. When it is defined, a zero divisor
// goes straight to DONE at the start edge instead of iterating.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start; result register holds the last answer
// CALC  | one non-restoring step per cycle, DATA_W cycles
// FIX   | restore negative remainder, apply signs, write result
// DONE  | done pulse for one cycle; a new start is accepted here
module nios2_cpu_div_cell #(
  parameter int               DATA_W    = 32,
  parameter logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic              E_div_rem,
  input  logic              M_kill,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_result
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  // partial remainder carries one extra bit as its sign
  logic [DATA_W:0]   rem_q, rem_d;
  // holds the dividend magnitude; its top bit is consumed each step while
  // quotient bits fill in from the bottom
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W:0]   divisor_q, divisor_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              rem_sel_q, rem_sel_d;

  logic              start_ok;
  logic              src1_neg;
  logic              src2_neg;
  logic [DATA_W:0]   src1_ext;
  logic [DATA_W:0]   src2_ext;
  logic [DATA_W:0]   src1_abs;
  logic [DATA_W:0]   src2_abs;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_step;
  logic [DATA_W-1:0] quot_step;
  logic [DATA_W-1:0] rem_mag;
  logic [DATA_W-1:0] quot_final;
  logic [DATA_W-1:0] rem_final;
  logic              div0;

  // Operand magnitudes with a sign-extended extra bit, so 0x80000000 keeps its
  // magnitude 2^31 after negation.
  always_comb begin
    start_ok = E_div_start && !M_kill;
    src1_neg = E_div_signed && E_src1[DATA_W-1];
    src2_neg = E_div_signed && E_src2[DATA_W-1];
    src1_ext = {src1_neg, E_src1};
    src2_ext = {src2_neg, E_src2};
    src1_abs = src1_neg ? (~src1_ext + 1'b1) : src1_ext;
    src2_abs = src2_neg ? (~src2_ext + 1'b1) : src2_ext;
  end

  // One non-restoring step: shift in the next dividend bit, then add or subtract
  // the divisor depending on the sign of the previous partial remainder. The
  // true result always fits in DATA_W+1 bits, so any intermediate wrap cancels.
  always_comb begin
    rem_shift = {rem_q[DATA_W-1:0], quot_q[DATA_W-1]};
    rem_step  = rem_q[DATA_W] ? (rem_shift + divisor_q) : (rem_shift - divisor_q);
    quot_step = {quot_q[DATA_W-2:0], ~rem_step[DATA_W]};
  end

  // Final correction: restore a negative remainder, then apply the latched signs.
  // A zero divisor leaves the remainder equal to the dividend magnitude, which
  // the dividend sign turns back into the original dividend.
  always_comb begin
    div0       = (divisor_q == '0);
    rem_mag    = rem_q[DATA_W-1:0] + (rem_q[DATA_W] ? divisor_q[DATA_W-1:0] : '0);
    rem_final  = r_neg_q ? (~rem_mag + 1'b1) : rem_mag;
    quot_final = div0 ? DIV0_QUOT : (q_neg_q ? (~quot_q + 1'b1) : quot_q);
  end

  // Next-state and next-output logic for the controller and datapath.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start_ok) begin
          rem_d     = '0;
          quot_d    = src1_abs[DATA_W-1:0];
          divisor_d = src2_abs;
          cnt_d     = CNT_W'(DATA_W - 1);
          q_neg_d   = src1_neg ^ src2_neg;
          r_neg_d   = src1_neg;
          rem_sel_d = E_div_rem;
`ifdef NIOS2_DIV_FAST_ZERO_EN
          if (E_src2 == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = E_div_rem ? E_src1 : DIV0_QUOT;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
`else
          state_d = S_CALC;
          busy_d  = 1'b1;
`endif
        end
      end

      S_CALC: begin
        if (M_kill) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        busy_d = 1'b0;
        if (M_kill) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = rem_sel_q ? rem_final : quot_final;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, registered outputs and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  assign M_div_busy   = busy_q;
  assign M_div_done   = done_q;
  assign M_div_result = result_q;

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// Bench for nios2_cpu_div_cell: arithmetic reference model plus directed vectors.
module tb_nios2_cpu_div_cell;

  localparam int LAT = 34;
`ifdef NIOS2_DIV_FAST_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int ZLAT = FAST ? 1 : LAT;

  logic        clk;
  logic        reset;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        E_div_start;
  logic        E_div_signed;
  logic        E_div_rem;
  logic        M_kill;
  logic        M_div_busy;
  logic        M_div_done;
  logic [31:0] M_div_result;

  int n_checks = 0;
  int n_fail   = 0;

  nios2_cpu_div_cell dut (
    .clk          (clk),
    .reset        (reset),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_div_start  (E_div_start),
    .E_div_signed (E_div_signed),
    .E_div_rem    (E_div_rem),
    .M_kill       (M_kill),
    .M_div_busy   (M_div_busy),
    .M_div_done   (M_div_done),
    .M_div_result (M_div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Truncating division computed on 64-bit magnitudes.
  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b,
                                             input bit sg, input bit rm);
    logic [63:0] ma, mb, q, r;
    bit an, bn;
    if (b == 32'd0) return rm ? a : 32'hFFFFFFFF;
    an = sg && a[31];
    bn = sg && b[31];
    ma = an ? (64'd0 - {32'hFFFFFFFF, a}) : {32'd0, a};
    mb = bn ? (64'd0 - {32'hFFFFFFFF, b}) : {32'd0, b};
    q  = ma / mb;
    r  = ma % mb;
    if (an ^ bn) q = 64'd0 - q;
    if (an) r = 64'd0 - r;
    return rm ? r[31:0] : q[31:0];
  endfunction

  // Cycle-level model: age counts edges since the accepted start.
  bit          m_active;
  int          m_age;
  int          m_done_age;
  logic [31:0] m_result;
  logic [31:0] m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active   = 1'b0;
      m_age      = 0;
      m_done_age = LAT;
      m_result   = 32'd0;
    end else if (m_active && m_age < m_done_age && M_kill) begin
      m_active = 1'b0;
    end else if (E_div_start && !M_kill && (!m_active || m_age == m_done_age)) begin
      m_pend     = exp_result(E_src1, E_src2, E_div_signed, E_div_rem);
      m_active   = 1'b1;
      m_age      = 1;
      m_done_age = (FAST && E_src2 == 32'd0) ? 1 : LAT;
      if (m_done_age == 1) m_result = m_pend;
    end else if (m_active) begin
      m_age++;
      if (m_age == m_done_age) m_result = m_pend;
      if (m_age > m_done_age) m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_busy",   {31'd0, M_div_busy}, {31'd0, m_active && m_age < m_done_age});
      check("model_done",   {31'd0, M_div_done}, {31'd0, m_active && m_age == m_done_age});
      check("model_result", M_div_result, m_result);
    end
  end

  task automatic wait_done(input string nm, input int cyc0, input logic [31:0] exp_val,
                           input int exp_lat);
    int cyc;
    cyc = cyc0;
    while (!M_div_done && cyc < cyc0 + 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!M_div_done) begin
      check({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({nm, "_value"}, M_div_result, exp_val);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit sg, input bit rm);
    E_src1       = a;
    E_src2       = b;
    E_div_signed = sg;
    E_div_rem    = rm;
    E_div_start  = 1'b1;
    @(negedge clk);
    E_div_start  = 1'b0;
    E_src1       = $urandom;
    E_src2       = $urandom;
    E_div_signed = 1'($urandom);
    E_div_rem    = 1'($urandom);
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input bit sg, input bit rm, input logic [31:0] exp_val,
                        input int exp_lat);
    launch(a, b, sg, rm);
    wait_done(nm, 1, exp_val, exp_lat);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset        = 1'b1;
    E_src1       = 32'd0;
    E_src2       = 32'd0;
    E_div_start  = 1'b0;
    E_div_signed = 1'b0;
    E_div_rem    = 1'b0;
    M_kill       = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_busy",   {31'd0, M_div_busy}, 32'd0);
    check("rst_done",   {31'd0, M_div_done}, 32'd0);
    check("rst_result", M_div_result, 32'd0);

    check("pin_model_q",  exp_result(32'd100, 32'd7, 1'b0, 1'b0), 32'd14);
    check("pin_model_sr", exp_result(32'hFFFFFF9C, 32'd7, 1'b1, 1'b1), 32'hFFFFFFFE);
    check("pin_model_ov", exp_result(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0), 32'h80000000);

    run_op("udiv_q",   32'd100, 32'd7, 1'b0, 1'b0, 32'd14, LAT);
    run_op("udiv_r",   32'd100, 32'd7, 1'b0, 1'b1, 32'd2, LAT);
    run_op("sdiv_q",   32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 32'hFFFFFFF2, LAT);
    run_op("sdiv_r",   32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, LAT);
    run_op("ovf_q",    32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, LAT);
    run_op("ovf_r",    32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'd0, LAT);
    run_op("big_q",    32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'hFFFFFFFF, LAT);
    run_op("bigd_r",   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 32'd1, LAT);
    run_op("small_q",  32'd5, 32'd9, 1'b0, 1'b0, 32'd0, LAT);
    run_op("small_r",  32'd5, 32'd9, 1'b0, 1'b1, 32'd5, LAT);
    run_op("sdz_q",    32'hFFFFFF9C, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, ZLAT);
    run_op("sdz_r",    32'hFFFFFF9C, 32'd0, 1'b1, 1'b1, 32'hFFFFFF9C, ZLAT);
    run_op("dz_q",     32'h12345678, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, ZLAT);
    run_op("dz_r",     32'h12345678, 32'd0, 1'b0, 1'b1, 32'h12345678, ZLAT);

    // kill in cycle 10, restart in cycle 12
    launch(32'd50, 32'd5, 1'b0, 1'b0);
    saw_done = 1'b0;
    repeat (9) begin
      @(negedge clk);
      saw_done |= M_div_done;
    end
    M_kill = 1'b1;
    @(negedge clk);
    M_kill = 1'b0;
    saw_done |= M_div_done;
    check("kill_busy",   {31'd0, M_div_busy}, 32'd0);
    check("kill_result", M_div_result, 32'h12345678);
    @(negedge clk);
    saw_done |= M_div_done;
    check("kill_nodone", {31'd0, saw_done}, 32'd0);
    launch(32'd81, 32'd9, 1'b0, 1'b0);
    wait_done("restart", 13, 32'd9, 46);
    @(negedge clk);

    // start while busy is ignored
    launch(32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    E_src1      = 32'd10;
    E_src2      = 32'd2;
    E_div_start = 1'b1;
    @(negedge clk);
    E_div_start = 1'b0;
    wait_done("busy_start", 6, 32'h55555555, LAT);
    @(negedge clk);

    // async reset between edges in cycle 20
    launch(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_busy",   {31'd0, M_div_busy}, 32'd0);
    check("areset_done",   {31'd0, M_div_done}, 32'd0);
    check("areset_result", M_div_result, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    run_op("post_reset", 32'd9, 32'd3, 1'b0, 1'b0, 32'd3, LAT);

    // start accepted in the DONE cycle
    launch(32'd200, 32'd10, 1'b0, 1'b0);
    wait_done("b2b_first", 1, 32'd20, LAT);
    launch(32'd200, 32'd10, 1'b0, 1'b1);
    wait_done("b2b_second", 1, 32'd0, LAT);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_cpu_div_cell.md
Name: nios2_cpu_div_cell

Overview:
- Iterative 32-bit integer divider for the CPU's M stage.
- Inverse companion to the 16x16 partial-product multiplier cells; serves div, divu and the remainder path.
- Accepts operands from the E stage on a start pulse and computes a radix-2 non-restoring division over 32 iteration cycles.
- Presents quotient or remainder on a registered result with a one-cycle done pulse; the pipeline stalls on busy.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.
- DIV0_QUOT, 32'hFFFFFFFF, quotient returned on divide-by-zero.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- E_src1  in  32  dividend.
- E_src2  in  32  divisor.
- E_div_start  in  1  start request; operands sampled on the same edge.
- E_div_signed  in  1  1 = two's-complement (div), 0 = unsigned (divu).
- E_div_rem  in  1  1 = return remainder, 0 = return quotient.
- M_kill  in  1  pipeline flush; abandons the current operation.
- M_div_busy  out  1  high while an operation is in flight.
- M_div_done  out  1  one-cycle pulse; M_div_result valid this cycle.
- M_div_result  out  32  quotient or remainder, held until the next accepted start.

Behaviour:
- Reset (async, active-high): state=IDLE; M_div_busy=0, M_div_done=0, M_div_result=0; internal quotient, remainder and counter cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start && !kill -> CALC.
  - Captures |dividend| and |divisor| (absolute values only when signed).
  - Captures the quotient sign (src1[31]^src2[31]) and the remainder sign (src1[31]), counter=31, sets busy.
- CALC: one non-restoring step per cycle.
  - 33-bit partial remainder: shift left, insert next dividend bit, add or subtract the divisor by the sign of the previous remainder; quotient bit = ~sign.
  - Counter==0 -> FIX.
- FIX: restores a negative remainder (+divisor), then applies sign correction.
  - Quotient negated if the quotient sign is set; remainder negated if the remainder sign is set.
  - Selects quotient or remainder per the latched E_div_rem, writes M_div_result, -> DONE.
- DONE: M_div_done=1 for exactly one cycle, busy=0, -> IDLE. A start in DONE is accepted as if in IDLE.
- Latency: start sampled at the end of cycle 0; CALC cycles 1-32; FIX cycle 33; done in cycle 34. Busy high cycles 1-33.
- Start while busy (CALC/FIX): ignored, no queueing.
- Kill: in CALC/FIX -> IDLE on the next edge; busy drops, no done, M_div_result unchanged. Kill with start in IDLE/DONE: start dropped.
- Divide-by-zero:
  - quotient = DIV0_QUOT.
  - remainder = dividend, unmodified, signed or unsigned.
  - Runs the full latency unless the optional feature is enabled.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Absolute values use 33-bit intermediates so no sign is lost.
- Remainder sign always follows the dividend (truncating division); |remainder| < |divisor|.
- Operand inputs may change after the start edge without effect.

Optional Feature:
- Macro: NIOS2_DIV_FAST_ZERO_EN.
- Defined: when the divisor is zero at start, the divider goes IDLE -> DONE directly, skipping CALC/FIX.
  - M_div_result is loaded at the start edge; done arrives in cycle 1; busy is never asserted.
  - Results are identical to the slow path.
- Undefined: divide-by-zero takes the normal 34-cycle path; no zero detector is synthesized.

Test Plan:
- Unsigned: src1=100, src2=7, signed=0, rem=0 -> done in cycle 34, result=14. Repeat with rem=1 -> result=2.
- Signed: src1=-100 (0xFFFFFF9C), src2=7, signed=1 -> quotient 0xFFFFFFF2 (-14); with rem=1, remainder 0xFFFFFFFE (-2).
- Overflow/zero:
  - 0x80000000 / 0xFFFFFFFF signed -> 0x80000000, rem 0.
  - 0x12345678 / 0 -> quotient 0xFFFFFFFF, rem 0x12345678.
  - Done in cycle 34, or cycle 1 with NIOS2_DIV_FAST_ZERO_EN.
- Kill/restart:
  - Start 50/5, kill in cycle 10 -> busy low in cycle 11, no done pulse, result unchanged.
  - Start 81/9 in cycle 12 -> done in cycle 46, result=9.
- Start while busy: start 0xFFFFFFFF/3 unsigned, pulse start with 10/2 in cycle 5 -> ignored; done in cycle 34, result=0x55555555.
- Async reset mid-CALC:
  - Assert reset between edges in cycle 20 -> busy, done and result go 0 immediately, without a clock edge.
  - After release, start 9/3 -> result 3.
